// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for the bit-serial adder.
// The slave side is the adder; the master side is whoever drives operands and consumes results.
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: LSB-first, one bit per clock, using a full adder
// built from two half adders and an OR, with a registered carry between bits.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  serial_adder_if.slave  bus
);
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] sum_sr;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             carry;
  logic [CNT_W-1:0] cnt;

  logic p, g1, s, g2, carry_next;
  logic [WIDTH-1:0] sum_shifted;

  // Returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  always_comb begin
    {g1, p}     = half_add(a_sr[0], b_sr[0]);
    {g2, s}     = half_add(p, carry);
    carry_next  = g1 | g2;
    sum_shifted = {s, sum_sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.in_valid)  state_next = SHIFT;
      SHIFT:   if (cnt == LAST)   state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // sum_sr accumulates the partial result so the visible sum only changes on completion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            carry <= bus.cin;
            cnt   <= '0;
          end
        end
        SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          sum_sr <= sum_shifted;
          carry  <= carry_next;
          cnt    <= cnt + CNT_W'(1);
          if (cnt == LAST) begin
            sum_q  <= sum_shifted;
            cout_q <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// Randomized and directed checks of serial_adder against an arithmetic reference
// (a + b + cin) plus handshake timing rules.
module tb_serial_adder;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  serial_adder_if #(.WIDTH(WIDTH)) bus ();

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WIDTH:0] ref_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
    return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for out_valid after an accept edge; returns cycles counted.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
  endtask

  task automatic do_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic c,
                       input string tag);
    logic [WIDTH:0] exp;
    int n;
    exp = ref_add(x, y, c);
    check_val({tag, "_in_ready"}, bus.in_ready, 1'b1);
    bus.in_valid = 1'b1; bus.a = x; bus.b = y; bus.cin = c; bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
    wait_done(n);
    check_val({tag, "_latency"}, n, WIDTH);
    check_val({tag, "_sum"}, bus.sum, exp[WIDTH-1:0]);
    check_val({tag, "_cout"}, bus.cout, exp[WIDTH]);
    tick();
    check_val({tag, "_ovalid_drop"}, bus.out_valid, 1'b0);
  endtask

  initial begin
    int n;
    logic [WIDTH:0] exp;
    logic [WIDTH:0] exp_q[$];
    logic [WIDTH-1:0] sa[3];
    logic [WIDTH-1:0] sb[3];
    logic sc[3];
    int idx, got, last_t;
    bit acc;

    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;

    // Reset with random inputs on the bus
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'($urandom); bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      bus.cin = 1'($urandom); bus.out_ready = 1'($urandom);
      tick();
    end
    check_val("rst_in_ready", bus.in_ready, 1'b0);
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_busy", bus.busy, 1'b0);
    check_val("rst_sum", bus.sum, 8'h00);
    check_val("rst_cout", bus.cout, 1'b0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_val("post_rst_in_ready", bus.in_ready, 1'b1);

    // Directed additions
    do_op(8'h3C, 8'h5A, 1'b0, "basic");
    do_op(8'hFF, 8'h01, 1'b0, "carry_ff_01");
    do_op(8'hFF, 8'hFF, 1'b1, "carry_ff_ff_1");
    do_op(8'h00, 8'h00, 1'b1, "carry_00_00_1");

    // Back-pressure: result held, new operand ignored until IDLE
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 8'h12; bus.b = 8'h34; bus.cin = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    wait_done(n);
    check_val("bp_latency", n, WIDTH);
    check_val("bp_sum", bus.sum, 8'h46);
    bus.in_valid = 1'b1; bus.a = 8'hAA; bus.b = 8'h01; bus.cin = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("bp_hold_sum", bus.sum, 8'h46);
      check_val("bp_hold_valid", bus.out_valid, 1'b1);
      check_val("bp_hold_in_ready", bus.in_ready, 1'b0);
    end
    bus.out_ready = 1'b1;
    tick();
    check_val("bp_idle_in_ready", bus.in_ready, 1'b1);
    check_val("bp_idle_valid", bus.out_valid, 1'b0);
    check_val("bp_idle_sum", bus.sum, 8'h46);
    tick();
    bus.in_valid = 1'b0;
    check_val("bp_aa_busy", bus.busy, 1'b1);
    wait_done(n);
    check_val("bp_aa_latency", n, WIDTH);
    check_val("bp_aa_sum", bus.sum, 8'hAB);
    check_val("bp_aa_cout", bus.cout, 1'b0);
    tick();

    // Reset during the third SHIFT cycle
    bus.in_valid = 1'b1; bus.a = 8'h80; bus.b = 8'h80; bus.cin = 1'b0;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    check_val("midrst_busy_before", bus.busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check_val("midrst_out_valid", bus.out_valid, 1'b0);
    check_val("midrst_busy", bus.busy, 1'b0);
    check_val("midrst_cout", bus.cout, 1'b0);
    check_val("midrst_sum", bus.sum, 8'h00);
    check_val("midrst_in_ready", bus.in_ready, 1'b0);
    rst_n = 1'b1;
    #1;
    do_op(8'h80, 8'h80, 1'b0, "after_midrst");

    // Randomized operations
    for (int i = 0; i < 20; i++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), "rand");

    // Streaming with in_valid and out_ready held high
    for (int i = 0; i < 3; i++) begin
      sa[i] = WIDTH'($urandom); sb[i] = WIDTH'($urandom); sc[i] = 1'($urandom);
    end
    idx = 0; got = 0; last_t = -1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.a = sa[0]; bus.b = sb[0]; bus.cin = sc[0];
    for (int t = 0; t < 100 && got < 3; t++) begin
      acc = bus.in_valid && bus.in_ready;
      if (acc) exp_q.push_back(ref_add(bus.a, bus.b, bus.cin));
      tick();
      if (acc) begin
        idx++;
        if (idx < 3) begin
          bus.a = sa[idx]; bus.b = sb[idx]; bus.cin = sc[idx];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
      if (bus.out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check_val("stream_sum", bus.sum, exp[WIDTH-1:0]);
        check_val("stream_cout", bus.cout, exp[WIDTH]);
        if (last_t >= 0) check_val("stream_spacing", t - last_t, WIDTH + 2);
        last_t = t;
        got++;
      end
    end
    check_val("stream_count", got, 3);
    bus.in_valid = 1'b0;
    tick();
    check_val("stream_end_valid", bus.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
